// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Purpose:
//   Shares one SDRAM controller FIFO port pair between a single-word board
//   writer and a burst row reader. Only one SDRAM transaction is in flight at
//   any time. While vs (vertical blank) is high a contending write wins;
//   otherwise contention is settled round-robin.
//
// Optional feature (compile-time macro ARB_WATCHDOG_EN):
//   Defined   : a watchdog counts cycles spent in W_DRAIN / R_WAIT. After
//               WDOG_CYC cycles there the transaction is dropped, err pulses
//               and the FSM returns to IDLE.
//   Undefined : no watchdog logic; err is constant 0.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   vs                vertical blank, write priority while high
//   w_req/w_addr/w_data/w_ack
//                     board write request (held until w_ack), address, data,
//                     one-cycle completion pulse
//   r_req/r_addr/r_len
//                     row read request (held until r_done), start address,
//                     burst length (0 -> 1, clamped to MAX_LEN)
//   r_valid/r_data/r_done
//                     burst word strobe, word, pulse with the final word
//   err               one-cycle watchdog abort pulse
//   write_ld/write_req/writeaddr/writedata/wr_buffer
//                     SDRAM write FIFO handshake and fill level
//   read_ld/read_req/readaddr/readdata/rd_buffer
//                     SDRAM read FIFO handshake, data and fill level
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int SETTLE_CYC = 12,   // cycles read_ld stays high after R_LD
  parameter int MAX_LEN    = 16,   // max burst words (must fit in 5 bits)
  parameter int WDOG_CYC   = 1024  // watchdog limit in cycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vs,
  input  logic        w_req,
  input  logic [24:0] w_addr,
  input  logic [15:0] w_data,
  output logic        w_ack,
  input  logic        r_req,
  input  logic [24:0] r_addr,
  input  logic [4:0]  r_len,
  output logic        r_valid,
  output logic [15:0] r_data,
  output logic        r_done,
  output logic        err,
  output logic        write_ld,
  output logic        write_req,
  output logic [24:0] writeaddr,
  output logic [15:0] writedata,
  input  logic [15:0] wr_buffer,
  output logic        read_ld,
  output logic        read_req,
  output logic [24:0] readaddr,
  input  logic [15:0] readdata,
  input  logic [15:0] rd_buffer
);

  typedef enum logic [2:0] {
    IDLE, W_LD, W_REQ, W_DRAIN, R_LD, R_SETTLE, R_WAIT, R_BURST
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [24:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [24:0] raddr_q, raddr_d;
  logic [4:0]  len_q, len_d;       // effective (already clamped) burst length
  logic        last_w_q, last_w_d; // 1: write received the most recent grant
  logic [15:0] cnt_q, cnt_d;       // settle / burst / first-drain-cycle counter
  logic        r_valid_q, r_valid_d;
  logic        r_done_q, r_done_d;
  logic [15:0] r_data_q, r_data_d;

  logic [4:0]  eff_len;
  logic [15:0] len_ext;

`ifdef ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  // Effective burst length of the incoming request.
  always_comb begin
    if (r_len == 5'd0) begin
      eff_len = 5'd1;
    end else if (int'(r_len) > MAX_LEN) begin
      eff_len = 5'(MAX_LEN);
    end else begin
      eff_len = r_len;
    end
  end

  assign len_ext = {11'd0, len_q};

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    len_d     = len_q;
    last_w_d  = last_w_q;
    cnt_d     = cnt_q;
    w_ack     = 1'b0;
    err       = 1'b0;
    write_ld  = 1'b0;
    write_req = 1'b0;
    writeaddr = 25'd0;
    writedata = 16'd0;
    read_ld   = 1'b0;
    read_req  = 1'b0;
    readaddr  = 25'd0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        // Write wins when alone, under vs, or when read had the last grant.
        if (w_req && (!r_req || vs || !last_w_q)) begin
          state_d  = W_LD;
          last_w_d = 1'b1;
        end else if (r_req) begin
          state_d  = R_LD;
          last_w_d = 1'b0;
        end
        if (w_req || r_req) begin
          waddr_d = w_addr;
          wdata_d = w_data;
          raddr_d = r_addr;
          len_d   = eff_len;
        end
      end
      W_LD: begin
        write_ld  = 1'b1;
        writeaddr = waddr_q;
        state_d   = W_REQ;
      end
      W_REQ: begin
        write_req = 1'b1;
        writedata = wdata_q;
        cnt_d     = 16'd0;
        state_d   = W_DRAIN;
      end
      W_DRAIN: begin
        // The FIFO level lags write_req by a cycle, so the first drain
        // cycle's wr_buffer is not trusted.
        if (cnt_q == 16'd0) begin
          cnt_d = 16'd1;
        end else if (wr_buffer == 16'd0) begin
          w_ack   = 1'b1;
          state_d = IDLE;
        end
      end
      R_LD: begin
        read_ld  = 1'b1;
        readaddr = raddr_q;
        cnt_d    = 16'd0;
        state_d  = R_SETTLE;
      end
      R_SETTLE: begin
        read_ld  = 1'b1;
        readaddr = raddr_q;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 16'd0;
          state_d = R_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_WAIT: begin
        if (rd_buffer >= len_ext) begin
          cnt_d   = 16'd0;
          state_d = R_BURST;
        end
      end
      R_BURST: begin
        // cnt_q == len is a tail cycle that carries the final r_valid/r_done
        // so the following IDLE cycle is free for arbitration.
        if (cnt_q == len_ext) begin
          state_d = IDLE;
        end else begin
          read_req = 1'b1;
          cnt_d    = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef ARB_WATCHDOG_EN
    // A normal exit in the same cycle takes precedence over the abort.
    wdog_d = '0;
    if ((state_q == W_DRAIN || state_q == R_WAIT) && (state_d == state_q)) begin
      if (wdog_q == WDOG_LAST) begin
        err     = 1'b1;
        state_d = IDLE;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  // Read return path: one register stage behind the FIFO request.
  assign r_valid_d = read_req;
  assign r_done_d  = read_req && (cnt_q == (len_ext - 16'd1));
  assign r_data_d  = readdata;

  assign r_valid = r_valid_q;
  assign r_done  = r_done_q;
  assign r_data  = r_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      waddr_q   <= 25'd0;
      wdata_q   <= 16'd0;
      raddr_q   <= 25'd0;
      len_q     <= 5'd0;
      last_w_q  <= 1'b0;   // read counts as last granted: first tie -> write
      cnt_q     <= 16'd0;
      r_valid_q <= 1'b0;
      r_done_q  <= 1'b0;
      r_data_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      len_q     <= len_d;
      last_w_q  <= last_w_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_done_q  <= r_done_d;
      r_data_q  <= r_data_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Directed bench. Each transaction task drives the inputs cycle by cycle and,
// from the arbiter's documented timing rules, states what every output must be
// in that cycle. A separate process compares the DUT at each falling edge and
// also checks hand-computed per-transaction pulse counts.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int SETTLE = 12;
  localparam int MAXL   = 16;
  localparam int WDOG   = 1024;

  logic        clk;
  logic        reset;
  logic        vs;
  logic        w_req;
  logic [24:0] w_addr;
  logic [15:0] w_data;
  logic        w_ack;
  logic        r_req;
  logic [24:0] r_addr;
  logic [4:0]  r_len;
  logic        r_valid;
  logic [15:0] r_data;
  logic        r_done;
  logic        err;
  logic        write_ld;
  logic        write_req;
  logic [24:0] writeaddr;
  logic [15:0] writedata;
  logic [15:0] wr_buffer;
  logic        read_ld;
  logic        read_req;
  logic [24:0] readaddr;
  logic [15:0] readdata;
  logic [15:0] rd_buffer;

  sdram_port_arbiter #(
    .SETTLE_CYC(SETTLE), .MAX_LEN(MAXL), .WDOG_CYC(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .vs(vs),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
    .r_req(r_req), .r_addr(r_addr), .r_len(r_len),
    .r_valid(r_valid), .r_data(r_data), .r_done(r_done), .err(err),
    .write_ld(write_ld), .write_req(write_req),
    .writeaddr(writeaddr), .writedata(writedata), .wr_buffer(wr_buffer),
    .read_ld(read_ld), .read_req(read_req),
    .readaddr(readaddr), .readdata(readdata), .rd_buffer(rd_buffer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          start;
    bit          fin;
    int          n_ld;
    int          n_req;
    int          n_val;
    int          n_done;
    int          n_err;
    logic        w_ack;
    logic        r_valid;
    logic        r_done;
    logic        err;
    logic        write_ld;
    logic        write_req;
    logic        read_ld;
    logic        read_req;
    logic [24:0] writeaddr;
    logic [15:0] writedata;
    logic [24:0] readaddr;
    logic [15:0] r_data;
  } exp_t;

  exp_t exp_v;
  int   errors = 0;
  int   checks = 0;

  // Pending end-of-transaction literals, emitted with the next cycle.
  bit pend_fin = 0;
  int pend_ld, pend_req, pend_val, pend_done, pend_err;

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > MAXL) return MAXL;
    return l;
  endfunction

  task automatic mk_blank(output exp_t e);
    e.chk = 1; e.start = 0; e.fin = 0;
    e.n_ld = 0; e.n_req = 0; e.n_val = 0; e.n_done = 0; e.n_err = 0;
    e.w_ack = 0; e.r_valid = 0; e.r_done = 0; e.err = 0;
    e.write_ld = 0; e.write_req = 0; e.read_ld = 0; e.read_req = 0;
    e.writeaddr = '0; e.writedata = '0; e.readaddr = '0; e.r_data = '0;
    if (pend_fin) begin
      e.fin = 1;
      e.n_ld = pend_ld; e.n_req = pend_req; e.n_val = pend_val;
      e.n_done = pend_done; e.n_err = pend_err;
      pend_fin = 0;
    end
  endtask

  task automatic set_pend(input int l, input int q, input int v, input int d, input int er);
    pend_ld = l; pend_req = q; pend_val = v; pend_done = d; pend_err = er;
    pend_fin = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      mk_blank(e);
      w_req = 0; r_req = 0; vs = 0;
      exp_v = e;
      tick();
    end
  endtask

  task automatic hold_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      mk_blank(e);
      reset = 0; w_req = 0; r_req = 0;
      exp_v = e;
      tick();
    end
    reset = 1;
  endtask

  // Write body: starts in the cycle after the grant.
  task automatic write_body(input logic [24:0] addr, input logic [15:0] data,
                            input int first_buf, input int ones, input bit chain_r,
                            input logic [24:0] ra, input logic [4:0] rl,
                            input int n_done, input int n_err);
    exp_t e;
    int   b;
    bit   ack, werr;
    r_req = 0; wr_buffer = 16'd1;
    w_addr = ~addr; w_data = ~data;       // latched values must be used
    mk_blank(e); e.write_ld = 1; e.writeaddr = addr; exp_v = e; tick();
    mk_blank(e); e.write_req = 1; e.writedata = data; exp_v = e; tick();
    for (int k = 0; k < 4000; k++) begin
      b = (k == 0) ? first_buf : ((k <= ones) ? 1 : 0);
      wr_buffer = 16'(b);
      ack = (k >= 1) && (b == 0);
`ifdef ARB_WATCHDOG_EN
      werr = !ack && (k == WDOG - 1);
`else
      werr = 0;
`endif
      mk_blank(e); e.w_ack = ack; e.err = werr;
      if (ack && chain_r) begin
        r_req = 1; r_addr = ra; r_len = rl;
      end
      exp_v = e;
      tick();
      if (ack || werr) break;
    end
    set_pend(1, 1, 0, n_done, n_err);
  endtask

  // Read body: starts in the cycle after the grant.
  task automatic read_body(input logic [24:0] addr, input int len, input int wait_extra,
                           input int abort_at, input int n_ld, input int n_req,
                           input int n_val, input int n_done);
    exp_t e;
    int   eff;
    bit   aborted;
    logic [15:0] d, prev;
    eff = eff_len(len);
    aborted = 0;
    prev = '0;
    w_req = 0;
    r_addr = ~addr; r_len = 5'd7;         // latched values must be used
    for (int i = 0; i < 1 + SETTLE; i++) begin
      rd_buffer = 16'hFFFF;               // ignored until settle completes
      mk_blank(e); e.read_ld = 1; e.readaddr = addr; exp_v = e; tick();
    end
    for (int j = 0; j <= wait_extra; j++) begin
      rd_buffer = (j < wait_extra) ? 16'(eff - 1) : 16'(eff);
      mk_blank(e); exp_v = e; tick();
    end
    for (int i = 0; i < eff; i++) begin
      d = 16'h3C00 + 16'(i) * 16'h0101;
      readdata = d;
      mk_blank(e);
      if (i == abort_at) begin
        reset = 0; r_req = 0;
        exp_v = e;
        tick();
        aborted = 1;
        break;
      end
      e.read_req = 1;
      if (i > 0) begin
        e.r_valid = 1; e.r_data = prev;
      end
      exp_v = e;
      tick();
      prev = d;
    end
    if (!aborted) begin
      mk_blank(e); e.r_valid = 1; e.r_data = prev; e.r_done = 1; exp_v = e; tick();
    end
    set_pend(n_ld, n_req, n_val, n_done, 0);
  endtask

  task automatic write_txn(input logic [24:0] addr, input logic [15:0] data,
                           input int first_buf, input int ones, input bit chain_r,
                           input logic [24:0] ra, input logic [4:0] rl,
                           input int n_done, input int n_err);
    exp_t e;
    $display("txn write addr=%h data=%h drain_ones=%0d", addr, data, ones);
    mk_blank(e); e.start = 1;
    w_req = 1; r_req = 0; w_addr = addr; w_data = data;
    exp_v = e;
    tick();
    write_body(addr, data, first_buf, ones, chain_r, ra, rl, n_done, n_err);
  endtask

  task automatic read_txn(input logic [24:0] addr, input int len, input int wait_extra,
                          input int abort_at, input int n_ld, input int n_req,
                          input int n_val, input int n_done);
    exp_t e;
    $display("txn read addr=%h len=%0d abort_at=%0d", addr, len, abort_at);
    mk_blank(e); e.start = 1;
    r_req = 1; w_req = 0; r_addr = addr; r_len = 5'(len);
    exp_v = e;
    tick();
    read_body(addr, len, wait_extra, abort_at, n_ld, n_req, n_val, n_done);
  endtask

  // Both requesters raise together; the loser withdraws after the grant.
  task automatic contend(input bit vs_in, input bit win_w, input logic [24:0] wa,
                         input logic [15:0] wd, input logic [24:0] ra);
    exp_t e;
    $display("txn contend vs=%0d expect %s", vs_in, win_w ? "write" : "read");
    mk_blank(e); e.start = 1;
    w_req = 1; r_req = 1; vs = vs_in;
    w_addr = wa; w_data = wd; r_addr = ra; r_len = 5'd4;
    exp_v = e;
    tick();
    vs = 0;
    if (win_w) write_body(wa, wd, 1, 0, 0, '0, '0, 1, 0);
    else       read_body(ra, 4, 0, -1, 13, 4, 4, 1);
  endtask

  // ---------------------------------------------------------------- compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, ex);
    end
  endtask

  int c_ld = 0, c_req = 0, c_val = 0, c_done = 0, c_err = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_v.chk) begin
        if (exp_v.fin) begin
          chk("count_ld", c_ld, exp_v.n_ld);
          chk("count_req", c_req, exp_v.n_req);
          chk("count_valid", c_val, exp_v.n_val);
          chk("count_done", c_done, exp_v.n_done);
          chk("count_err", c_err, exp_v.n_err);
        end
        if (exp_v.start) begin
          c_ld = 0; c_req = 0; c_val = 0; c_done = 0; c_err = 0;
        end
        c_ld   += int'(write_ld | read_ld);
        c_req  += int'(write_req | read_req);
        c_val  += int'(r_valid);
        c_done += int'(w_ack | r_done);
        c_err  += int'(err);
        chk("w_ack", w_ack, exp_v.w_ack);
        chk("r_valid", r_valid, exp_v.r_valid);
        chk("r_done", r_done, exp_v.r_done);
        chk("err", err, exp_v.err);
        chk("write_ld", write_ld, exp_v.write_ld);
        chk("write_req", write_req, exp_v.write_req);
        chk("read_ld", read_ld, exp_v.read_ld);
        chk("read_req", read_req, exp_v.read_req);
        chk("writeaddr", writeaddr, exp_v.writeaddr);
        chk("writedata", writedata, exp_v.writedata);
        chk("readaddr", readaddr, exp_v.readaddr);
        if (exp_v.r_valid || !reset) chk("r_data", r_data, exp_v.r_data);
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    exp_t e;
    reset = 0; vs = 0; w_req = 0; r_req = 0;
    w_addr = '0; w_data = '0; r_addr = '0; r_len = '0;
    wr_buffer = '0; rd_buffer = '0; readdata = '0;
    mk_blank(e);
    exp_v = e;
    for (int i = 0; i < 3; i++) tick();
    reset = 1;
    idle(2);

    // Single write, wr_buffer 1 then 0.
    write_txn(25'h00000A2, 16'h005F, 1, 0, 0, '0, '0, 1, 0);
    idle(2);
    // First drain cycle reports empty: must be ignored.
    write_txn(25'h1FFFFFF, 16'hFFFF, 0, 2, 0, '0, '0, 1, 0);
    idle(1);
    // Read burst of 10 words: 13 read_ld, 10 read_req, 10 r_valid, 1 r_done.
    read_txn(25'h00000C8, 10, 0, -1, 13, 10, 10, 1);
    idle(2);
    // Read request raised in the w_ack cycle: granted in the next IDLE cycle.
    write_txn(25'h0ABCDEF, 16'h1234, 1, 1, 1, 25'h0123456, 5'd5, 1, 0);
    read_txn(25'h0123456, 5, 3, -1, 13, 5, 5, 1);
    idle(1);
    // Length edges.
    read_txn(25'h0000010, 0, 1, -1, 13, 1, 1, 1);
    idle(1);
    read_txn(25'h0000020, 20, 2, -1, 13, 16, 16, 1);
    idle(1);
    read_txn(25'h0000030, 16, 0, -1, 13, 16, 16, 1);
    idle(1);
    // Contention: vs=1 -> W, then vs=0 -> R, W, R.
    contend(1, 1, 25'h0000100, 16'hAAAA, 25'h0000200);
    idle(1);
    contend(0, 0, 25'h0000101, 16'hBBBB, 25'h0000201);
    idle(1);
    contend(0, 1, 25'h0000102, 16'hCCCC, 25'h0000202);
    idle(1);
    contend(0, 0, 25'h0000103, 16'hDDDD, 25'h0000203);
    idle(1);
    // Reset during the 5th burst word: no r_done, outputs cleared at once.
    read_txn(25'h0000300, 8, 0, 4, 13, 4, 3, 0);
    hold_reset(2);
    // Reset restores "read last granted": a vs=0 tie goes to write.
    contend(0, 1, 25'h0000400, 16'h4444, 25'h0000500);
    idle(1);
    read_txn(25'h0000600, 3, 0, -1, 13, 3, 3, 1);
    idle(2);
    // Stuck drain.
`ifdef ARB_WATCHDOG_EN
    write_txn(25'h0000700, 16'h7777, 1, 3000, 0, '0, '0, 0, 1);
`else
    write_txn(25'h0000700, 16'h7777, 1, 1100, 0, '0, '0, 1, 0);
`endif
    idle(2);
    read_txn(25'h0000800, 2, 0, -1, 13, 2, 2, 1);
    idle(3);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
